// File: rtl/seq_detector.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detector
//  Purpose  : Parametrised serial sequence recognizer. Watches the 1-bit
//             serial input `a` (qualified by `en`) for a LEN-bit PATTERN,
//             MSB received first. Produces a combinational Mealy match `m`,
//             a registered copy `n` one cycle later, and a saturating match
//             counter. Overlapping or non-overlapping detection is selected
//             by OVERLAP.
//  Ports    : clk   - clock, all state updates on posedge
//             rst   - asynchronous active-high reset
//             en    - sample enable, `a` consumed only when en=1
//             clear - synchronous clear of history, n and count
//             a     - serial data input
//             m     - combinational match for the current cycle
//             n     - registered match, one cycle after m
//             count - number of matches, saturating at all-ones
//  Macro    : SEQ_DET_TIMEOUT_EN - when defined, an idle counter discards a
//             partial sequence after IDLE_MAX consecutive cycles with en=0.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_detector #(
    parameter int             LEN      = 4,
    parameter logic [LEN-1:0] PATTERN  = 4'b1101,
    parameter bit             OVERLAP  = 1'b1,
    parameter int             CNT_W    = 8,
    parameter int             IDLE_MAX = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic             a,
    output logic             m,
    output logic             n,
    output logic [CNT_W-1:0] count
);

    localparam int                  c_FILL_W   = $clog2(LEN);
    localparam logic [c_FILL_W-1:0] c_FILL_MAX = c_FILL_W'(LEN - 1);

    generate
        if (LEN < 2 || LEN > 32 || CNT_W < 1 || IDLE_MAX < 1) begin : g_bad_param
            $error("seq_detector: illegal parameter combination");
        end
    endgenerate

    logic [LEN-2:0]      r_hist;
    logic [LEN-2:0]      w_hist_next;
    logic [c_FILL_W-1:0] r_fill;
    logic [c_FILL_W-1:0] w_fill_next;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W:0]      w_cnt_inc;
    logic                r_n;
    logic                w_match;
    logic                w_idle_hit;

    // Newest bit enters at the LSB; LEN=2 has a single history bit.
    generate
        if (LEN == 2) begin : g_hist_len2
            assign w_hist_next = a;
        end else begin : g_hist_wide
            assign w_hist_next = {r_hist[LEN-3:0], a};
        end
    endgenerate

    // rst is included so m stays low for as long as reset is held.
    assign w_match = en & ~clear & ~rst & (r_fill == c_FILL_MAX)
                   & ({r_hist, a} == PATTERN);

    // Extra top bit flags that count is already all-ones.
    assign w_cnt_inc = {1'b0, r_count} + 1'b1;

    always_comb begin
        w_fill_next = r_fill;
        if (w_match && !OVERLAP) begin
            w_fill_next = '0;
        end else if (r_fill != c_FILL_MAX) begin
            w_fill_next = r_fill + 1'b1;
        end
    end

`ifdef SEQ_DET_TIMEOUT_EN
    localparam int                  c_IDLE_W   = $clog2(IDLE_MAX + 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_MAX = c_IDLE_W'(IDLE_MAX);

    logic [c_IDLE_W-1:0] r_idle;
    logic [c_IDLE_W-1:0] w_idle_next;

    assign w_idle_next = (r_idle == c_IDLE_MAX) ? r_idle : r_idle + 1'b1;
    // Fires on the edge where the idle count reaches (or sits at) the limit.
    assign w_idle_hit  = (w_idle_next == c_IDLE_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle <= '0;
        end else if (clear || en) begin
            r_idle <= '0;
        end else begin
            r_idle <= w_idle_next;
        end
    end
`else
    assign w_idle_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_n     <= 1'b0;
            r_count <= '0;
        end else begin
            r_n <= w_match;
            if (clear) begin
                r_hist  <= '0;
                r_fill  <= '0;
                r_n     <= 1'b0;
                r_count <= '0;
            end else if (en) begin
                r_hist <= w_hist_next;
                r_fill <= w_fill_next;
                if (w_match && !w_cnt_inc[CNT_W]) begin
                    r_count <= w_cnt_inc[CNT_W-1:0];
                end
            end else if (w_idle_hit) begin
                r_fill <= '0;
            end
        end
    end

    assign m     = w_match;
    assign n     = r_n;
    assign count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_detector
//  Purpose  : Directed self-checking bench for seq_detector. Four instances
//             share the stimulus: default (overlap), non-overlap, non-overlap
//             with a 2-bit counter, and IDLE_MAX=4 for the idle timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detector;

`ifdef SEQ_DET_TIMEOUT_EN
    localparam bit c_TO_ON = 1'b1;
`else
    localparam bit c_TO_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, en, clear, a;

    logic       m_ov, n_ov;
    logic [7:0] cnt_ov;
    logic       m_no, n_no;
    logic [7:0] cnt_no;
    logic       m_c2, n_c2;
    logic [1:0] cnt_c2;
    logic       m_to, n_to;
    logic [7:0] cnt_to;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_detector #(.LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8), .IDLE_MAX(16)) dut_ov (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .a(a),
        .m(m_ov), .n(n_ov), .count(cnt_ov));

    seq_detector #(.LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(8), .IDLE_MAX(16)) dut_no (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .a(a),
        .m(m_no), .n(n_no), .count(cnt_no));

    seq_detector #(.LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(2), .IDLE_MAX(16)) dut_c2 (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .a(a),
        .m(m_c2), .n(n_c2), .count(cnt_c2));

    seq_detector #(.LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8), .IDLE_MAX(4)) dut_to (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .a(a),
        .m(m_to), .n(n_to), .count(cnt_to));

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkc(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check m mid-cycle, check n after posedge.
    task automatic step(input logic av, input logic env, input logic clrv,
                        input logic e_ov, input logic e_no, input logic e_to);
        @(negedge clk);
        a = av; en = env; clear = clrv;
        #1;
        chk1("m_ov", m_ov, e_ov);
        chk1("m_no", m_no, e_no);
        chk1("m_c2", m_c2, e_no);
        chk1("m_to", m_to, e_to);
        @(posedge clk);
        #1;
        chk1("n_ov", n_ov, e_ov);
        chk1("n_no", n_no, e_no);
        chk1("n_c2", n_c2, e_no);
        chk1("n_to", n_to, e_to);
    endtask

    task automatic do_clear();
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chkc("cnt_ov_clr", int'(cnt_ov), 0);
        chkc("cnt_no_clr", int'(cnt_no), 0);
        chkc("cnt_c2_clr", int'(cnt_c2), 0);
        chkc("cnt_to_clr", int'(cnt_to), 0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; clear = 1'b0; a = 1'b1;
        // Reset state, m forced low while rst held
        @(posedge clk); @(posedge clk); #1;
        chk1("rst_m_ov", m_ov, 1'b0);
        chk1("rst_m_to", m_to, 1'b0);
        chk1("rst_n_ov", n_ov, 1'b0);
        chkc("rst_cnt_ov", int'(cnt_ov), 0);
        chkc("rst_cnt_c2", int'(cnt_c2), 0);
        @(negedge clk); rst = 1'b0;

        // Stream 1,1,0,1,1,0,1: overlap matches bits 4 and 7, non-overlap bit 4
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 1, 1, 1);
        step(1, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0, 1);
        chkc("t1_cnt_ov", int'(cnt_ov), 2);
        chkc("t2_cnt_no", int'(cnt_no), 1);
        chkc("t2_cnt_c2", int'(cnt_c2), 1);

        // 1101 five times: 2-bit counter saturates at 3
        do_clear();
        for (int k = 1; k <= 5; k++) begin
            step(1, 1, 0, 0, 0, 0);
            step(1, 1, 0, 0, 0, 0);
            step(0, 1, 0, 0, 0, 0);
            step(1, 1, 0, 1, 1, 1);
            chkc("t3_cnt_c2", int'(cnt_c2), (k < 3) ? k : 3);
            chkc("t3_cnt_no", int'(cnt_no), k);
            chkc("t3_cnt_ov", int'(cnt_ov), k);
        end

        // Reset mid-sequence discards partial history
        do_clear();
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1; a = 1'b1; en = 1'b1;
        #1;
        chk1("t4_rst_m_ov", m_ov, 1'b0);
        chk1("t4_rst_m_no", m_no, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        chk1("t4_rst_n_ov", n_ov, 1'b0);
        @(negedge clk); rst = 1'b0;
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 1, 1, 1);
        chkc("t4_cnt_ov", int'(cnt_ov), 1);

        // History held across en=0 with a toggling
        do_clear();
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 1, 1);
        chkc("t5_cnt_ov", int'(cnt_ov), 1);

        // Clear during the gap wipes history and count
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        chkc("t5c_cnt_ov", int'(cnt_ov), 0);
        chkc("t5c_cnt_no", int'(cnt_no), 0);

        // 4-cycle idle gap: IDLE_MAX=4 instance drops the partial sequence
        do_clear();
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) step(k[0], 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 1, !c_TO_ON);

        // 3-cycle idle gap: below the limit, match survives everywhere
        do_clear();
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(k[0], 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 1, 1);
        chkc("t6_cnt_to", int'(cnt_to), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
